// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified IF/DM memory port arbiter.
// Holds the FSM state encoding, the fetch access size and the latched attribute record.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

  typedef struct packed {
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_attr_t;

  // Fetches are always full-word loads with no store data.
  function automatic mem_attr_t fetch_attr(input logic [31:0] addr);
    mem_attr_t a;
    a.we    = 1'b0;
    a.func3 = FUNC3_WORD;
    a.addr  = addr;
    a.wdata = 32'd0;
    return a;
  endfunction

endpackage

// File: rtl/mem_req_latch.sv
// Attribute register for the outstanding memory transaction (we, func3, addr, wdata).
// Loaded once per grant so the memory sees stable attributes while mem_req is high.
module mem_req_latch
  import mem_port_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  mem_attr_t d,
  output mem_attr_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and data (DM) with DM priority
// and a streak limit that guarantees fetch eventually gets a grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_func3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  function automatic logic [SW-1:0] streak_sat_inc(input logic [SW-1:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 1'b1;
  endfunction

  arb_state_t      state, state_nxt;
  logic [SW-1:0]   streak, streak_nxt;
  logic            latch_load;
  mem_attr_t       latch_d;
  mem_attr_t       attr_q;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    latch_load = 1'b0;
    latch_d    = '{we: dm_we, func3: dm_func3, addr: dm_addr, wdata: dm_wdata};
    unique case (state)
      ARB_IDLE: begin
        // DM wins unless IF is waiting and DM has already used up its streak.
        if (dm_req && (!if_req || (streak < STREAK_MAX))) begin
          state_nxt  = ARB_DM_BUSY;
          latch_load = 1'b1;
          streak_nxt = if_req ? streak_sat_inc(streak) : '0;
        end else if (if_req) begin
          state_nxt  = ARB_IF_BUSY;
          latch_load = 1'b1;
          latch_d    = fetch_attr(if_addr);
          streak_nxt = '0;
        end
      end
      ARB_IF_BUSY, ARB_DM_BUSY: begin
        if (mem_ack) state_nxt = ARB_RESP;
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  mem_req_latch u_req_latch (
    .clk  (clk),
    .rst  (rst),
    .load (latch_load),
    .d    (latch_d),
    .q    (attr_q)
  );

  // Response registers: the valid pulse lands in RESP, the cycle after mem_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= 32'd0;
      dm_rdata <= 32'd0;
    end else begin
      if_valid <= (state == ARB_IF_BUSY) && mem_ack;
      dm_valid <= (state == ARB_DM_BUSY) && mem_ack;
      if ((state == ARB_IF_BUSY) && mem_ack) if_rdata <= mem_rdata;
      if ((state == ARB_DM_BUSY) && mem_ack) dm_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (state == ARB_IF_BUSY) || (state == ARB_DM_BUSY);
  assign mem_we    = attr_q.we;
  assign mem_func3 = attr_q.func3;
  assign mem_addr  = attr_q.addr;
  assign mem_wdata = attr_q.wdata;

  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [2:0]  dm_func3;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall;
  logic [2:0]  mem_func3;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.MAX_DM_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_func3(dm_func3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_func3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_dm;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [2:0]  exp_func3;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  // Reference model state: who owns the port, who is being answered, DM grant streak.
  int          m_owner;   // 0 none, 1 IF, 2 DM
  int          m_resp;    // 0 none, 1 IF, 2 DM
  int          m_streak;
  logic        m_we;
  logic [2:0]  m_func3;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          prev_resp;
  int          wait_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_func3 = 0;
    dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_owner = 0; m_resp = 0; m_streak = 0; m_we = 0; m_func3 = 0;
    m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
    prev_resp = 0; wait_cnt = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    do_reset();
    if_req = v.if_req; if_addr = v.if_addr;
    dm_req = v.dm_req; dm_we = v.dm_we; dm_func3 = v.dm_func3;
    dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    tick(); #2;
    check({t, "_mem_req"}, mem_req, 1);
    check({t, "_mem_addr"}, mem_addr, v.exp_addr);
    check({t, "_mem_we"}, mem_we, v.exp_we);
    check({t, "_mem_func3"}, mem_func3, v.exp_func3);
    check({t, "_mem_wdata"}, mem_wdata, v.exp_wdata);
    for (int c = 1; c < v.delay; c++) begin
      tick(); #2;
      check({t, "_attr_stable"}, mem_addr, v.exp_addr);
    end
    mem_ack = 1; mem_rdata = v.rdata;
    tick(); mem_ack = 0; #2;
    check({t, "_if_valid"}, if_valid, !v.exp_dm);
    check({t, "_dm_valid"}, dm_valid, v.exp_dm);
    if (!v.exp_dm) check({t, "_if_rdata"}, if_rdata, v.rdata);
    else if (!v.exp_we) check({t, "_dm_rdata"}, dm_rdata, v.rdata);
    check({t, "_stall_resp"}, stall, (v.if_req && v.exp_dm) || (v.dm_req && !v.exp_dm));
    if_req = 0; dm_req = 0;
    tick(); #2;
    check({t, "_idle_req"}, mem_req, 0);
    check({t, "_idle_valid"}, {if_valid, dm_valid}, 0);
  endtask

  task automatic lone_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h40;
    tick(); #2;
    check("lf_mem_req", mem_req, 1);
    check("lf_mem_addr", mem_addr, 32'h40);
    check("lf_mem_we", mem_we, 0);
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'h00A00093; #2;
    check("lf_stall_c3", stall, 1);
    check("lf_valid_c3", if_valid, 0);
    tick(); mem_ack = 0; #2;
    check("lf_valid_c4", if_valid, 1);
    check("lf_rdata_c4", if_rdata, 32'h00A00093);
    check("lf_stall_c4", stall, 0);
    if_req = 0;
    tick(); #2;
    check("lf_valid_c5", if_valid, 0);
  endtask

  task automatic starvation();
    logic [31:0] exp_order[6];
    int t;
    exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
    do_reset();
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_addr = 32'h300; dm_we = 0; dm_func3 = 3'b010;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      tick();
      while (mem_req !== 1'b1 && t < 10) begin
        tick();
        t++;
      end
      if (t >= 10) begin
        check("starve_timeout", 0, 1);
        break;
      end
      check($sformatf("starve_grant%0d", g), mem_addr, exp_order[g]);
      mem_ack = 1; mem_rdata = 32'h1000 + g;
      tick(); mem_ack = 0; #2;
      check($sformatf("starve_valid%0d", g), {if_valid, dm_valid},
            (exp_order[g] == 32'h200) ? 2'b10 : 2'b01);
    end
    if_req = 0; dm_req = 0;
    tick();
  endtask

  task automatic mid_events();
    // Reset in DM_BUSY abandons the transaction.
    do_reset();
    dm_req = 1; dm_addr = 32'h120; dm_we = 1; dm_wdata = 32'h55;
    tick(); #2;
    check("rst_busy_req", mem_req, 1);
    rst = 1; #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_addr", mem_addr, 0);
    dm_req = 0;
    tick(); rst = 0;
    mem_ack = 1;
    tick(); mem_ack = 0; #2;
    check("rst_no_valid", {if_valid, dm_valid}, 0);
    check("rst_idle_req", mem_req, 0);
    // Spurious ack while idle is ignored.
    mem_ack = 1;
    tick(); mem_ack = 0; #2;
    check("spur_no_valid", {if_valid, dm_valid}, 0);
    check("spur_no_req", mem_req, 0);
    if_req = 1; if_addr = 32'h44;
    tick(); #2;
    check("spur_then_grant", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'hBEEF;
    tick(); mem_ack = 0; if_req = 0; #2;
    check("spur_then_valid", if_valid, 1);
    // A request dropped mid-transaction still completes.
    tick();
    dm_req = 1; dm_addr = 32'h180; dm_we = 0;
    tick(); dm_req = 0;
    mem_ack = 1; mem_rdata = 32'hCAFE;
    tick(); mem_ack = 0; #2;
    check("drop_valid", dm_valid, 1);
    check("drop_rdata", dm_rdata, 32'hCAFE);
    tick(); #2;
    check("drop_valid_once", dm_valid, 0);
  endtask

  task automatic drive_random();
    if (!if_req) begin
      if ($urandom_range(0, 1) == 1) begin if_req = 1; if_addr = $urandom & ~32'd3; end
    end else if (prev_resp == 1) begin
      if ($urandom_range(0, 1) == 1) if_req = 0;
      else if_addr = $urandom & ~32'd3;
    end
    if (!dm_req) begin
      if ($urandom_range(0, 3) != 0) begin
        dm_req = 1; dm_we = $urandom_range(0, 1); dm_func3 = $urandom_range(0, 7);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end else if (prev_resp == 2) begin
      if ($urandom_range(0, 1) == 1) dm_req = 0;
      else begin dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom; end
    end
    mem_rdata = $urandom;
    if (m_owner != 0) begin
      mem_ack = (wait_cnt == 0);
      if (wait_cnt != 0) wait_cnt--;
    end else begin
      mem_ack = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic compare_random();
    check("rnd_mem_req", mem_req, m_owner != 0);
    check("rnd_mem_addr", mem_addr, m_addr);
    check("rnd_mem_we", mem_we, m_we);
    check("rnd_mem_func3", mem_func3, m_func3);
    check("rnd_mem_wdata", mem_wdata, m_wdata);
    check("rnd_if_valid", if_valid, m_resp == 1);
    check("rnd_dm_valid", dm_valid, m_resp == 2);
    check("rnd_stall", stall, (if_req && m_resp != 1) || (dm_req && m_resp != 2));
    check("rnd_if_rdata", if_rdata, m_if_rdata);
    if (m_resp == 2 && !m_we) check("rnd_dm_rdata", dm_rdata, m_dm_rdata);
  endtask

  // Transaction-level rules: one outstanding access, answer next cycle, then re-arbitrate.
  task automatic model_step();
    prev_resp = m_resp;
    if (m_resp != 0) begin
      m_resp = 0;
    end else if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 1) m_if_rdata = mem_rdata;
        else m_dm_rdata = mem_rdata;
        m_resp = m_owner;
        m_owner = 0;
      end
    end else if (dm_req && !(if_req && m_streak == MAX)) begin
      m_owner = 2;
      m_we = dm_we; m_func3 = dm_func3; m_addr = dm_addr; m_wdata = dm_wdata;
      m_streak = if_req ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
      wait_cnt = $urandom_range(0, 2);
    end else if (if_req) begin
      m_owner = 1;
      m_we = 0; m_func3 = 3'b010; m_addr = if_addr; m_wdata = 0;
      m_streak = 0;
      wait_cnt = $urandom_range(0, 2);
    end
  endtask

  initial begin
    vecs[0] = '{1, 32'h40, 0, 0, 3'b000, 32'h0, 32'h0, 3, 32'h00A00093,
                0, 32'h40, 0, 3'b010, 32'h0};
    vecs[1] = '{1, 32'h80, 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'h12345678,
                1, 32'h100, 0, 3'b010, 32'h0};
    vecs[2] = '{0, 32'h0, 1, 1, 3'b000, 32'h104, 32'hFF, 4, 32'h0,
                1, 32'h104, 1, 3'b000, 32'hFF};
    vecs[3] = '{0, 32'h0, 1, 0, 3'b100, 32'h2A1, 32'hDEAD, 1, 32'h000000A5,
                1, 32'h2A1, 0, 3'b100, 32'hDEAD};
    vecs[4] = '{1, 32'h1FFC, 0, 1, 3'b001, 32'h500, 32'h77, 1, 32'hFFFF0000,
                0, 32'h1FFC, 0, 3'b010, 32'h0};

    do_reset();
    #2;
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_attr", {mem_we, mem_func3}, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_valids", {if_valid, dm_valid}, 0);
    check("reset_rdata", if_rdata | dm_rdata, 0);
    check("reset_stall", stall, 0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
    lone_fetch();
    starvation();
    mid_events();

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      #2;
      compare_random();
      model_step();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
